// File: rtl/branch_update_gen.sv
// Predictor update producer: tracks in-flight predictions and emits normal or rollback updates.
// Optional stats counters are built when BRANCH_UPDATE_STATS_EN is defined.
module branch_update_gen #(
   parameter int INDEX_LEN                = 8,
   parameter int FIFO_DEPTH               = 8,
   parameter int MAX_ROLLBACK_CYCLES_INCL = 16,
   parameter int ROLLBACK_W               = $clog2(MAX_ROLLBACK_CYCLES_INCL + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          is_stalling,
   input  logic                          pred_valid,
   input  logic [INDEX_LEN-1:0]          pred_index,
   input  logic                          pred_taken,
   output logic                          pred_ready,
   input  logic                          resolve_valid,
   input  logic                          resolve_taken,
   output logic                          upd_enable,
   output logic                          upd_is_rollback,
   output logic                          upd_taken,
   output logic [INDEX_LEN-1:0]          upd_index,
   output logic [ROLLBACK_W-1:0]         upd_rollback_cycles,
   output logic [$clog2(FIFO_DEPTH):0]   occupancy,
   output logic                          overflow_err,
   output logic                          underflow_err,
   output logic [15:0]                   resolved_count,
   output logic [15:0]                   mispredict_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CTR_W = ROLLBACK_W + 4;
   localparam logic [CTR_W-1:0]      MAX_AGE = CTR_W'(MAX_ROLLBACK_CYCLES_INCL);
   localparam logic [ROLLBACK_W-1:0] MAX_RB  = ROLLBACK_W'(MAX_ROLLBACK_CYCLES_INCL);

   logic [INDEX_LEN-1:0] mem_index [FIFO_DEPTH];
   logic                 mem_taken [FIFO_DEPTH];
   logic [CTR_W-1:0]     mem_stamp [FIFO_DEPTH];

   logic [PTR_W:0]       wr_ptr;
   logic [PTR_W:0]       rd_ptr;
   logic [CTR_W-1:0]     cycle_ctr;

   logic                 empty;
   logic                 full;
   logic [INDEX_LEN-1:0] head_index;
   logic                 head_taken;
   logic [CTR_W-1:0]     head_stamp;
   logic [CTR_W-1:0]     head_age;
   logic [ROLLBACK_W-1:0] rb_cycles;
   logic                 pop;
   logic                 mispredict;
   logic                 pop_match;
   logic                 push;
   logic                 overflow_set;
   logic                 underflow_set;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign head_index = mem_index[rd_ptr[PTR_W-1:0]];
   assign head_taken = mem_taken[rd_ptr[PTR_W-1:0]];
   assign head_stamp = mem_stamp[rd_ptr[PTR_W-1:0]];

   // Modular age so a wrapped cycle_ctr still yields the correct distance.
   assign head_age  = cycle_ctr - head_stamp;
   assign rb_cycles = (head_age > MAX_AGE) ? MAX_RB : head_age[ROLLBACK_W-1:0];

   assign pop           = resolve_valid && !is_stalling && !empty;
   assign mispredict    = pop && (resolve_taken != head_taken);
   assign pop_match     = pop && !mispredict;
   assign underflow_set = resolve_valid && !is_stalling && empty;

   // A matching pop frees a slot, so a push while full still lands; a flush discards wrong-path pushes.
   assign push         = pred_valid && !is_stalling && !mispredict && (!full || pop_match);
   assign overflow_set = pred_valid && !is_stalling && full && !pop;

   assign pred_ready = !full;
   assign occupancy  = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_index[wr_ptr[PTR_W-1:0]] <= pred_index;
         mem_taken[wr_ptr[PTR_W-1:0]] <= pred_taken;
         mem_stamp[wr_ptr[PTR_W-1:0]] <= cycle_ctr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cycle_ctr     <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else if (!is_stalling) begin
         cycle_ctr <= cycle_ctr + 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (mispredict) begin
            rd_ptr <= wr_ptr;
         end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (overflow_set) begin
            overflow_err <= 1'b1;
         end
         if (underflow_set) begin
            underflow_err <= 1'b1;
         end
      end
   end

   // Update outputs hold through a stall so a pending update survives until it drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         upd_enable          <= 1'b0;
         upd_is_rollback     <= 1'b0;
         upd_taken           <= 1'b0;
         upd_index           <= '0;
         upd_rollback_cycles <= '0;
      end else if (!is_stalling) begin
         upd_enable          <= pop;
         upd_is_rollback     <= mispredict;
         upd_taken           <= pop ? resolve_taken : 1'b0;
         upd_index           <= pop ? head_index : '0;
         upd_rollback_cycles <= mispredict ? rb_cycles : '0;
      end
   end

`ifdef BRANCH_UPDATE_STATS_EN
   logic [15:0] resolved_q;
   logic [15:0] mispredict_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resolved_q   <= '0;
         mispredict_q <= '0;
      end else if (!is_stalling) begin
         if (pop && (resolved_q != 16'hFFFF)) begin
            resolved_q <= resolved_q + 16'd1;
         end
         if (mispredict && (mispredict_q != 16'hFFFF)) begin
            mispredict_q <= mispredict_q + 16'd1;
         end
      end
   end

   assign resolved_count   = resolved_q;
   assign mispredict_count = mispredict_q;
`else
   assign resolved_count   = 16'd0;
   assign mispredict_count = 16'd0;
`endif

endmodule

// File: tb/tb_branch_update_gen.sv
// Scoreboard bench for branch_update_gen: a queue model of in-flight predictions predicts each update.
module tb_branch_update_gen;

   localparam int FD   = 8;
   localparam int MAXR = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        is_stalling;
   logic        pred_valid;
   logic [7:0]  pred_index;
   logic        pred_taken;
   logic        pred_ready;
   logic        resolve_valid;
   logic        resolve_taken;
   logic        upd_enable;
   logic        upd_is_rollback;
   logic        upd_taken;
   logic [7:0]  upd_index;
   logic [4:0]  upd_rollback_cycles;
   logic [3:0]  occupancy;
   logic        overflow_err;
   logic        underflow_err;
   logic [15:0] resolved_count;
   logic [15:0] mispredict_count;

   always #5 clk = ~clk;

   branch_update_gen dut (
      .clk                 (clk),
      .reset               (reset),
      .is_stalling         (is_stalling),
      .pred_valid          (pred_valid),
      .pred_index          (pred_index),
      .pred_taken          (pred_taken),
      .pred_ready          (pred_ready),
      .resolve_valid       (resolve_valid),
      .resolve_taken       (resolve_taken),
      .upd_enable          (upd_enable),
      .upd_is_rollback     (upd_is_rollback),
      .upd_taken           (upd_taken),
      .upd_index           (upd_index),
      .upd_rollback_cycles (upd_rollback_cycles),
      .occupancy           (occupancy),
      .overflow_err        (overflow_err),
      .underflow_err       (underflow_err),
      .resolved_count      (resolved_count),
      .mispredict_count    (mispredict_count)
   );

   typedef struct packed {logic pv; logic [7:0] pi; logic pt; logic rv; logic rt; logic st;} step_t;
   typedef struct packed {logic en; logic rb; logic tk; logic [7:0] idx; logic [4:0] cyc;} upd_t;
   typedef struct packed {logic [7:0] idx; logic tk; int unsigned stamp;} ent_t;

   upd_t        exp_q[$];
   ent_t        fifo_m[$];
   upd_t        last_e;
   int unsigned m_ctr;
   bit          m_ovf, m_unf;
   int          m_res, m_mis;
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic step_t stp(bit pv, logic [7:0] pi, bit pt, bit rv, bit rt, bit st);
      return {pv, pi, pt, rv, rt, st};
   endfunction

   task automatic idle_inputs();
      is_stalling   = 1'b0;
      pred_valid    = 1'b0;
      pred_index    = 8'h00;
      pred_taken    = 1'b0;
      resolve_valid = 1'b0;
      resolve_taken = 1'b0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      fifo_m.delete();
      last_e = '0;
      m_ctr  = 0;
      m_ovf  = 0;
      m_unf  = 0;
      m_res  = 0;
      m_mis  = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_model();
   endtask

   // Drives one clock of stimulus and pushes the expected update for that edge.
   task automatic drive_step(input step_t s);
      upd_t        e;
      ent_t        h;
      bit          pop, mis, full, push_ok;
      int unsigned age;
      is_stalling   = s.st;
      pred_valid    = s.pv;
      pred_index    = s.pi;
      pred_taken    = s.pt;
      resolve_valid = s.rv;
      resolve_taken = s.rt;
      if (s.st) begin
         e = last_e;
      end else begin
         e    = '0;
         pop  = s.rv && (fifo_m.size() != 0);
         mis  = 0;
         full = (fifo_m.size() == FD);
         if (s.rv && !pop) m_unf = 1;
         if (pop) begin
            h     = fifo_m[0];
            mis   = (s.rt != h.tk);
            age   = (m_ctr - h.stamp) % 512;
            e.en  = 1'b1;
            e.rb  = mis;
            e.tk  = s.rt;
            e.idx = h.idx;
            if (mis) e.cyc = (age > MAXR) ? 5'(MAXR) : 5'(age);
            m_res++;
            if (mis) m_mis++;
         end
         if (s.pv && full && !pop) m_ovf = 1;
         push_ok = s.pv && !mis && (!full || pop);
         if (mis) fifo_m.delete();
         else if (pop) void'(fifo_m.pop_front());
         if (push_ok) fifo_m.push_back({s.pi, s.pt, m_ctr});
         m_ctr  = (m_ctr + 1) % 512;
         last_e = e;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      #3;
      n_cmp++;
      if ({upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_upd actual=%h expected=0000",
                  {upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles});
      end
      n_cmp++;
      if ({pred_ready, occupancy, overflow_err, underflow_err} !== 7'b1_0000_00) begin
         n_err++;
         $display("FAIL reset_state actual=ready%b occ%0d ovf%b unf%b expected=ready1 occ0 ovf0 unf0",
                  pred_ready, occupancy, overflow_err, underflow_err);
      end
      do_reset();
   endtask

   task automatic test_push_resolve();
      step_t steps[$];
      upd_t  e;
      steps.push_back(stp(1, 8'h11, 1, 0, 0, 0));
      steps.push_back(stp(1, 8'h22, 0, 0, 0, 0));
      steps.push_back(stp(1, 8'h33, 1, 0, 0, 0));
      steps.push_back(stp(0, 8'h00, 0, 1, 1, 0));
      foreach (steps[i]) begin
         drive_step(steps[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles} !== e) begin
            n_err++;
            $display("FAIL push_resolve_upd step%0d actual=%h expected=%h", i,
                     {upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles}, e);
         end
         n_cmp++;
         if (occupancy !== 4'(fifo_m.size())) begin
            n_err++;
            $display("FAIL push_resolve_occ step%0d actual=%0d expected=%0d", i, occupancy, fifo_m.size());
         end
         if (i == 2) begin
            n_cmp++;
            if ({occupancy, pred_ready, upd_enable} !== {4'd3, 1'b1, 1'b0}) begin
               n_err++;
               $display("FAIL three_pushed actual=occ%0d ready%b en%b expected=occ3 ready1 en0",
                        occupancy, pred_ready, upd_enable);
            end
         end
      end
      n_cmp++;
      if ({upd_enable, upd_is_rollback, upd_index, occupancy} !== {1'b1, 1'b0, 8'h11, 4'd2}) begin
         n_err++;
         $display("FAIL first_resolve actual=en%b rb%b idx%h occ%0d expected=en1 rb0 idx11 occ2",
                  upd_enable, upd_is_rollback, upd_index, occupancy);
      end
   endtask

   task automatic test_rollback_stall();
      step_t steps[$];
      upd_t  e;
      steps.push_back(stp(0, 8'h00, 0, 1, 0, 0));
      steps.push_back(stp(0, 8'h00, 0, 1, 1, 0));
      steps.push_back(stp(1, 8'h44, 0, 0, 0, 0));
      repeat (4) steps.push_back(stp(0, 8'h00, 0, 0, 0, 0));
      repeat (2) steps.push_back(stp(0, 8'h00, 0, 0, 0, 1));
      steps.push_back(stp(0, 8'h00, 0, 1, 1, 0));
      foreach (steps[i]) begin
         drive_step(steps[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles} !== e) begin
            n_err++;
            $display("FAIL rollback_upd step%0d actual=%h expected=%h", i,
                     {upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles}, e);
         end
      end
      n_cmp++;
      if ({upd_is_rollback, upd_rollback_cycles, upd_index, occupancy} !== {1'b1, 5'd5, 8'h44, 4'd0}) begin
         n_err++;
         $display("FAIL rollback_5 actual=rb%b cyc%0d idx%h occ%0d expected=rb1 cyc5 idx44 occ0",
                  upd_is_rollback, upd_rollback_cycles, upd_index, occupancy);
      end
   endtask

   task automatic test_stall_hold();
      step_t steps[$];
      upd_t  e;
      steps.push_back(stp(1, 8'h55, 1, 0, 0, 0));
      steps.push_back(stp(0, 8'h00, 0, 1, 1, 0));
      steps.push_back(stp(1, 8'h56, 0, 1, 1, 1));
      steps.push_back(stp(1, 8'h57, 0, 1, 0, 1));
      foreach (steps[i]) begin
         drive_step(steps[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles} !== e) begin
            n_err++;
            $display("FAIL stall_hold_upd step%0d actual=%h expected=%h", i,
                     {upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles}, e);
         end
      end
      n_cmp++;
      if ({upd_enable, upd_index, occupancy, underflow_err} !== {1'b1, 8'h55, 4'd0, 1'b0}) begin
         n_err++;
         $display("FAIL stall_freeze actual=en%b idx%h occ%0d unf%b expected=en1 idx55 occ0 unf0",
                  upd_enable, upd_index, occupancy, underflow_err);
      end
   endtask

   task automatic test_saturate();
      upd_t e;
      drive_step(stp(1, 8'h66, 1, 0, 0, 0));
      void'(exp_q.pop_front());
      repeat (40) begin
         drive_step(stp(0, 8'h00, 0, 0, 0, 0));
         void'(exp_q.pop_front());
      end
      drive_step(stp(0, 8'h00, 0, 1, 0, 0));
      e = exp_q.pop_front();
      n_cmp++;
      if ({upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles} !== e) begin
         n_err++;
         $display("FAIL saturate_upd actual=%h expected=%h",
                  {upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles}, e);
      end
      n_cmp++;
      if ({upd_is_rollback, upd_rollback_cycles} !== {1'b1, 5'd16}) begin
         n_err++;
         $display("FAIL saturate_16 actual=rb%b cyc%0d expected=rb1 cyc16", upd_is_rollback, upd_rollback_cycles);
      end
   endtask

   task automatic test_full();
      step_t steps[$];
      upd_t  e;
      for (int k = 0; k < 8; k++) steps.push_back(stp(1, 8'h80 + 8'(k), k[0], 0, 0, 0));
      steps.push_back(stp(1, 8'h90, 1, 1, 0, 0));
      steps.push_back(stp(1, 8'h91, 1, 0, 0, 0));
      steps.push_back(stp(1, 8'h92, 0, 1, 0, 0));
      foreach (steps[i]) begin
         drive_step(steps[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles} !== e) begin
            n_err++;
            $display("FAIL full_upd step%0d actual=%h expected=%h", i,
                     {upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles}, e);
         end
         n_cmp++;
         if ({occupancy, pred_ready, overflow_err} !== {4'(fifo_m.size()), fifo_m.size() != FD, m_ovf}) begin
            n_err++;
            $display("FAIL full_state step%0d actual=occ%0d ready%b ovf%b expected=occ%0d ready%b ovf%b", i,
                     occupancy, pred_ready, overflow_err, fifo_m.size(), fifo_m.size() != FD, m_ovf);
         end
         if (i == 8) begin
            n_cmp++;
            if ({occupancy, upd_index, overflow_err} !== {4'd8, 8'h80, 1'b0}) begin
               n_err++;
               $display("FAIL full_push_pop actual=occ%0d idx%h ovf%b expected=occ8 idx80 ovf0",
                        occupancy, upd_index, overflow_err);
            end
         end
         if (i == 9) begin
            n_cmp++;
            if ({occupancy, overflow_err} !== {4'd8, 1'b1}) begin
               n_err++;
               $display("FAIL overflow actual=occ%0d ovf%b expected=occ8 ovf1", occupancy, overflow_err);
            end
         end
      end
   endtask

   task automatic test_underflow();
      upd_t e;
      drive_step(stp(0, 8'h00, 0, 1, 1, 0));
      e = exp_q.pop_front();
      n_cmp++;
      if ({upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles} !== e) begin
         n_err++;
         $display("FAIL underflow_upd actual=%h expected=%h",
                  {upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles}, e);
      end
      n_cmp++;
      if ({upd_enable, underflow_err} !== {1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL underflow actual=en%b unf%b expected=en0 unf1", upd_enable, underflow_err);
      end
   endtask

   task automatic test_async_reset();
      drive_step(stp(1, 8'hA1, 1, 0, 0, 0));
      drive_step(stp(1, 8'hA2, 1, 0, 0, 0));
      drive_step(stp(0, 8'h00, 0, 1, 1, 0));
      exp_q.delete();
      is_stalling = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles} !== 16'h0) begin
         n_err++;
         $display("FAIL async_reset_upd actual=%h expected=0000",
                  {upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles});
      end
      n_cmp++;
      if ({pred_ready, occupancy, overflow_err, underflow_err, resolved_count, mispredict_count} !==
          {1'b1, 4'd0, 1'b0, 1'b0, 16'd0, 16'd0}) begin
         n_err++;
         $display("FAIL async_reset_state actual=ready%b occ%0d ovf%b unf%b res%0d mis%0d expected=ready1 all0",
                  pred_ready, occupancy, overflow_err, underflow_err, resolved_count, mispredict_count);
      end
      do_reset();
   endtask

   task automatic test_stats();
      step_t steps[$];
      upd_t  e;
      int    exp_res, exp_mis;
      do_reset();
      repeat (3) steps.push_back(stp(1, 8'hC0, 1, 0, 0, 0));
      steps.push_back(stp(0, 8'h00, 0, 1, 1, 0));
      steps.push_back(stp(0, 8'h00, 0, 1, 1, 0));
      steps.push_back(stp(0, 8'h00, 0, 1, 0, 0));
      foreach (steps[i]) begin
         drive_step(steps[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles} !== e) begin
            n_err++;
            $display("FAIL stats_upd step%0d actual=%h expected=%h", i,
                     {upd_enable, upd_is_rollback, upd_taken, upd_index, upd_rollback_cycles}, e);
         end
      end
`ifdef BRANCH_UPDATE_STATS_EN
      exp_res = 3;
      exp_mis = 1;
`else
      exp_res = 0;
      exp_mis = 0;
`endif
      n_cmp++;
      if ({resolved_count, mispredict_count} !== {16'(exp_res), 16'(exp_mis)}) begin
         n_err++;
         $display("FAIL stats_counts actual=res%0d mis%0d expected=res%0d mis%0d",
                  resolved_count, mispredict_count, exp_res, exp_mis);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      clear_model();
      test_reset();
      test_push_resolve();
      test_rollback_stall();
      test_stall_hold();
      test_saturate();
      test_full();
      test_underflow();
      test_async_reset();
      test_stats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_update_gen.md
# branch_update_gen

Producer side of the predictor update channel. Tracks in-flight predictions in a FIFO, matches in-order resolutions against them, and drives the `update.enable/taken/index/is_rollback/no_stall_rollback_cycles` fields consumed by the global and local history tables. On a correct prediction it emits a normal update. On a mispredict it emits a rollback sized to the non-stalled cycles elapsed since that prediction, then flushes younger entries.

## Interface
Parameters:
- `INDEX_LEN`, 8: width of the predictor index.
- `FIFO_DEPTH`, 8: maximum in-flight predictions; power of two, ≥2.
- `MAX_ROLLBACK_CYCLES_INCL`, 16: saturation value of the rollback cycle count.
- `ROLLBACK_W`, `$clog2(MAX_ROLLBACK_CYCLES_INCL+1)`: width of the rollback count.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `is_stalling`, in, 1: global stall; freezes all state.
- `pred_valid`, in, 1: a prediction was issued this cycle.
- `pred_index`, in, INDEX_LEN: index of the issued prediction.
- `pred_taken`, in, 1: predicted direction.
- `pred_ready`, out, 1: FIFO not full.
- `resolve_valid`, in, 1: the oldest in-flight branch resolved this cycle.
- `resolve_taken`, in, 1: actual direction.
- `upd_enable`, out, 1: update valid.
- `upd_is_rollback`, out, 1: update is a rollback.
- `upd_taken`, out, 1: actual direction of the resolved branch.
- `upd_index`, out, INDEX_LEN: index of the resolved branch.
- `upd_rollback_cycles`, out, ROLLBACK_W: history shift-back amount.
- `occupancy`, out, `$clog2(FIFO_DEPTH)+1`: number of entries in flight.
- `overflow_err`, out, 1: sticky; set by a push while full.
- `underflow_err`, out, 1: sticky; set by a resolve while empty.
- `resolved_count`, out, 16: stats counter (see Configuration).
- `mispredict_count`, out, 16: stats counter (see Configuration).

## Operation
- Entry = {index, pred_taken, stamp}.
- `cycle_ctr`: ROLLBACK_W+4 bits, free-running, increments on every non-stalled edge. It wraps modulo its width.
- Push: `pred_valid && !is_stalling && !full` writes an entry with stamp = `cycle_ctr`.
- Resolve: `resolve_valid && !is_stalling && !empty` pops the head. It compares `resolve_taken` against the head's `pred_taken`.
  - Match: `upd_enable=1`, `upd_is_rollback=0`, `upd_taken=resolve_taken`, `upd_index=head.index`, `upd_rollback_cycles=0`.
  - Mismatch: `upd_enable=1`, `upd_is_rollback=1`, `upd_taken=resolve_taken`, `upd_index=head.index`.
    - `upd_rollback_cycles = min(cycle_ctr - head.stamp, MAX_ROLLBACK_CYCLES_INCL)`, using modular subtraction.
    - The entire FIFO is flushed: head=tail, occupancy=0.
- No resolve on a non-stalled edge: `upd_enable` <= 0.
- Simultaneous push and matching resolve: both happen. This is allowed when full, since the pop frees a slot, so `pred_ready` = `!full || (resolve_valid && head matches)` is not used; `pred_ready` is strictly `!full`.
- Simultaneous push and mispredict: the flush wins and the push is discarded (it is wrong-path).
- Push while full: dropped; sets `overflow_err`.
- Resolve while empty: ignored; `upd_enable` <= 0; sets `underflow_err`.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer MSB.

## Timing
- All `upd_*` outputs are registered. They are valid on the edge after the resolve edge (1-cycle latency).
- While `is_stalling=1`:
  - no push, pop, counter increment, or error-flag update;
  - `upd_*` outputs hold their values, so a pending update is presented to consumers once the stall drops.
- `pred_ready`, `occupancy`, and the error flags are registered state. They reflect the last non-stalled edge.
- Reset (async, any cycle, including mid-flush or during a stall):
  - all outputs go to 0, with `pred_ready=1`;
  - pointers, `cycle_ctr`, and counters are cleared;
  - FIFO contents are don't-care.
- First push is accepted on the first rising edge after `reset` deasserts.

## Configuration
- `BRANCH_UPDATE_STATS_EN` defined:
  - `resolved_count` increments on every accepted resolve.
  - `mispredict_count` increments on every rollback.
  - Both are 16-bit, saturate at 0xFFFF, freeze during stall, and clear on reset.
- Not defined: the counters are not instantiated and both ports are tied to 0.

## Test plan
- Reset then push 3 entries (idx 0x11/T, 0x22/N, 0x33/T), no stall -> `occupancy=3`, `pred_ready=1`, `upd_enable=0`.
- Resolve the head with taken=1 -> next cycle: `upd_enable=1`, `is_rollback=0`, `upd_index=0x11`, `occupancy=2`.
- Push idx 0x44/N, wait 4 non-stalled cycles plus 2 stalled cycles, then resolve with taken=1 -> `is_rollback=1`, `upd_rollback_cycles=5` (push edge to resolve edge, stalls excluded), `upd_index=0x44`, `occupancy=0`.
- Push a prediction then wait 40 cycles before a mispredict resolve -> `upd_rollback_cycles=16` (saturated).
- Fill 8 entries, then push plus matching resolve in the same cycle -> still accepted, `occupancy=8`. A further push alone -> dropped, `overflow_err=1`.
- Resolve while empty -> `underflow_err=1`, `upd_enable=0`. Assert `reset` mid-stream -> all outputs 0 asynchronously. With `BRANCH_UPDATE_STATS_EN` defined, after 2 good and 1 bad resolves -> `resolved_count=3`, `mispredict_count=1`.
